sensor_frame_tx: RTL and testbench



---
 rtl/sensor_frame_tx.sv | 161 ++++++++++++++++
 tb/tb_sensor_frame_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_tx.sv
// sensor_frame_tx: clamps heart-rate/SpO2 samples, converts them to ASCII decimal
// with a sequential double-dabble and streams the frame "S:HHHSS\n" over valid/ready.
// Optional build macro: FRAME_CHECKSUM_EN inserts the XOR of bytes 0-6 as two
// uppercase ASCII hex digits before the newline (10-byte frame instead of 8).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sample_tick              request to build and send one frame
//   heart_rate[15:0], spo2   raw samples (bpm, percent)
//   tx_data, tx_valid        frame byte stream to the UART
//   tx_ready                 UART accepts the current byte
//   busy                     frame being converted or sent
//   frame_done               high in the cycle the last byte transfers
//   frame_drop               pulse for a tick ignored while busy
//   sat                      either input of the current frame was clamped
module sensor_frame_tx #(
    parameter logic [7:0] CMD_CHAR = 8'h53,
    parameter int         HR_MAX   = 999,
    parameter int         SPO2_MAX = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_tick,
    input  logic [15:0] heart_rate,
    input  logic [7:0]  spo2,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_drop,
    output logic        sat
);
`ifdef FRAME_CHECKSUM_EN
    localparam logic [3:0] LAST = 4'd9;
`else
    localparam logic [3:0] LAST = 4'd7;
`endif
    localparam logic [15:0] HR_LIM = 16'(HR_MAX);
    localparam logic [7:0]  SP_LIM = 8'(SPO2_MAX);

    typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

    state_t      r_state, w_state_nx;
    logic [9:0]  r_hr_sh, r_sp_sh;
    logic [11:0] r_hr_bcd, w_hr_adj;
    logic [7:0]  r_sp_bcd, w_sp_adj;
    logic [3:0]  r_cnt, r_idx, w_nidx;
    logic        r_valid, r_drop, r_sat;
    logic [7:0]  r_data;
    logic        w_hr_hi, w_sp_hi, w_start, w_conv_end, w_xfer, w_last;
    logic [9:0]  w_hr_c;
    logic [6:0]  w_sp_c;
    logic [7:0]  w_bytes [16];
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]  w_cs;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return n < 4'd10 ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction
`endif

    function automatic logic [3:0] dd(input logic [3:0] n);
        return n >= 4'd5 ? n + 4'd3 : n;
    endfunction

    assign w_hr_hi    = heart_rate > HR_LIM;
    assign w_sp_hi    = spo2 > SP_LIM;
    assign w_hr_c     = w_hr_hi ? HR_LIM[9:0] : heart_rate[9:0];
    assign w_sp_c     = w_sp_hi ? SP_LIM[6:0] : spo2[6:0];
    assign w_hr_adj   = {dd(r_hr_bcd[11:8]), dd(r_hr_bcd[7:4]), dd(r_hr_bcd[3:0])};
    assign w_sp_adj   = {dd(r_sp_bcd[7:4]), dd(r_sp_bcd[3:0])};
    assign w_start    = (r_state == IDLE) && sample_tick;
    assign w_conv_end = (r_state == CONV) && (r_cnt == 4'd9);
    assign w_xfer     = r_valid && tx_ready;
    assign w_last     = w_xfer && (r_idx == LAST);
    assign w_nidx     = r_idx + 4'd1;

    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    w_state_nx = sample_tick ? CONV : IDLE;
            CONV:    w_state_nx = w_conv_end ? SEND : CONV;
            SEND:    w_state_nx = w_last ? IDLE : SEND;
            default: w_state_nx = IDLE;
        endcase
    end

    // Digits are < 10, so ASCII is just the nibble under a 0x3 high nibble.
    always_comb begin
        for (int k = 0; k < 16; k++) w_bytes[k] = 8'h00;
        w_bytes[0] = CMD_CHAR;
        w_bytes[1] = 8'h3A;
        w_bytes[2] = {4'h3, r_hr_bcd[11:8]};
        w_bytes[3] = {4'h3, r_hr_bcd[7:4]};
        w_bytes[4] = {4'h3, r_hr_bcd[3:0]};
        w_bytes[5] = {4'h3, r_sp_bcd[7:4]};
        w_bytes[6] = {4'h3, r_sp_bcd[3:0]};
`ifdef FRAME_CHECKSUM_EN
        w_cs = w_bytes[0] ^ w_bytes[1] ^ w_bytes[2] ^ w_bytes[3] ^ w_bytes[4] ^ w_bytes[5] ^ w_bytes[6];
        w_bytes[7] = hex(w_cs[7:4]);
        w_bytes[8] = hex(w_cs[3:0]);
        w_bytes[9] = 8'h0A;
`else
        w_bytes[7] = 8'h0A;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hr_sh  <= '0;
            r_sp_sh  <= '0;
            r_hr_bcd <= '0;
            r_sp_bcd <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_data   <= 8'h00;
            r_drop   <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_drop <= sample_tick && (r_state != IDLE);
            if (w_start) begin
                r_hr_sh  <= w_hr_c;
                r_sp_sh  <= {3'b000, w_sp_c};
                r_hr_bcd <= '0;
                r_sp_bcd <= '0;
                r_cnt    <= '0;
                r_sat    <= w_hr_hi || w_sp_hi;
            end
            // Both conversions share one counter; the shift-out pulls the next
            // binary MSB into the adjusted BCD digits.
            if (r_state == CONV) begin
                {r_hr_bcd, r_hr_sh} <= {w_hr_adj, r_hr_sh} << 1;
                {r_sp_bcd, r_sp_sh} <= {w_sp_adj, r_sp_sh} << 1;
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_conv_end) begin
                r_valid <= 1'b1;
                r_data  <= CMD_CHAR;
                r_idx   <= '0;
            end
            // Data only moves on a transfer, so it holds through stalls.
            if (w_xfer) begin
                r_idx   <= w_nidx;
                r_data  <= w_bytes[w_nidx];
                r_valid <= !w_last;
            end
        end
    end

    assign tx_data    = r_data;
    assign tx_valid   = r_valid;
    assign busy       = r_state != IDLE;
    assign frame_done = w_last;
    assign frame_drop = r_drop;
    assign sat        = r_sat;
endmodule

// File: tb/tb_sensor_frame_tx.sv
// tb_sensor_frame_tx: table-driven, hand-sequenced and randomized checks of sensor_frame_tx.
module tb_sensor_frame_tx;
`ifdef FRAME_CHECKSUM_EN
    localparam int LEN = 10;
`else
    localparam int LEN = 8;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_tick = 1'b0;
    logic [15:0] heart_rate = '0;
    logic [7:0]  spo2 = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy, frame_done, frame_drop, sat;

    int          vecs = 0;
    int          errs = 0;
    logic [7:0]  exp_b [10];
    logic [7:0]  got [10];

    typedef struct {
        int hr;
        int sp;
        int exp_hr;
        int exp_sp;
        bit exp_sat;
        int stall;
    } vec_t;

    sensor_frame_tx dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .heart_rate(heart_rate),
        .spo2(spo2), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done), .frame_drop(frame_drop), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model(input int h, input int s);
        string hx = "0123456789ABCDEF";
        logic [7:0] cs = 8'h00;
        exp_b[0] = 8'h53;
        exp_b[1] = 8'h3A;
        exp_b[2] = 8'(48 + h / 100);
        exp_b[3] = 8'(48 + (h / 10) % 10);
        exp_b[4] = 8'(48 + h % 10);
        exp_b[5] = 8'(48 + s / 10);
        exp_b[6] = 8'(48 + s % 10);
        for (int i = 0; i < 7; i++) cs = cs ^ exp_b[i];
        if (LEN == 10) begin
            exp_b[7] = hx[cs / 16];
            exp_b[8] = hx[cs % 16];
            exp_b[9] = 8'h0A;
        end else begin
            exp_b[7] = 8'h0A;
        end
    endtask

    // Tick one frame from IDLE, collect it with tx_ready low stall% of cycles,
    // optionally fire extra ticks at cycle drop_c and/or on the final transfer.
    task automatic send_frame(input int hr, input int sp, input int eh, input int es,
                              input bit esat, input int stall, input bit timed,
                              input int drop_c, input bit drop_last);
        int n = 0, c = 1, first = -1, done = -1;
        bit hold = 0;
        logic [7:0] hold_d = 8'h00;
        model(eh, es);
        heart_rate = 16'(hr);
        spo2 = 8'(sp);
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        heart_rate = 16'($urandom);
        spo2 = 8'($urandom);
        while (done < 0 && c < 400) begin
            sample_tick = (c == drop_c);
            tx_ready = ($urandom_range(99) >= 32'(stall));
            #1;
            chk("busy", busy, 1);
            chk("frame_drop", frame_drop, int'(c - 1 == drop_c));
            if (hold) begin
                chk("stall valid", tx_valid, 1);
                chk("stall data", tx_data, hold_d);
            end
            if (tx_valid && first < 0) first = c;
            chk("frame_done", frame_done, int'(tx_valid && tx_ready && n == LEN - 1));
            if (tx_valid && tx_ready) begin
                got[n] = tx_data;
                n++;
                if (n == LEN) begin
                    done = c;
                    if (drop_last) sample_tick = 1'b1;
                end
            end
            hold = tx_valid && !tx_ready;
            hold_d = tx_data;
            @(posedge clk); #1;
            c++;
        end
        sample_tick = 1'b0;
        chk("frame completed", int'(done >= 0), 1);
        for (int i = 0; i < n; i++) chk($sformatf("byte%0d", i), got[i], exp_b[i]);
        if (timed) begin
            chk("first valid cycle", first, 11);
            chk("done cycle", done, LEN + 10);
        end
        chk("busy after frame", busy, 0);
        chk("valid after frame", tx_valid, 0);
        chk("drop after last", frame_drop, int'(drop_last));
        chk("sat", sat, int'(esat));
        if (drop_last) begin
            @(posedge clk); #1;
            chk("no queued frame", busy, 0);
        end
    endtask

    initial begin
        vec_t tbl [9];
        tbl[0] = '{75, 98, 75, 98, 0, 0};
        tbl[1] = '{1250, 120, 999, 99, 1, 0};
        tbl[2] = '{0, 0, 0, 0, 0, 50};
        tbl[3] = '{999, 99, 999, 99, 0, 30};
        tbl[4] = '{1000, 50, 999, 50, 1, 0};
        tbl[5] = '{123, 100, 123, 99, 1, 20};
        tbl[6] = '{5, 7, 5, 7, 0, 60};
        tbl[7] = '{65535, 255, 999, 99, 1, 0};
        tbl[8] = '{500, 99, 500, 99, 0, 40};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset tx_data", tx_data, 0);
        chk("reset tx_valid", tx_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset frame_drop", frame_drop, 0);
        chk("reset sat", sat, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            send_frame(tbl[i].hr, tbl[i].sp, tbl[i].exp_hr, tbl[i].exp_sp, tbl[i].exp_sat,
                       tbl[i].stall, tbl[i].stall == 0, -1, 0);

        send_frame(75, 98, 75, 98, 0, 0, 1, 5, 1);
        send_frame(432, 61, 432, 61, 0, 0, 1, 12, 0);

        heart_rate = 16'd321;
        spo2 = 8'd45;
        tx_ready = 1'b1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("pre-reset valid", tx_valid, 1);
        chk("pre-reset byte4", tx_data, 8'h31);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset abort valid", tx_valid, 0);
        chk("reset abort busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("idle after abort", tx_valid, 0);
        end
        send_frame(321, 45, 321, 45, 0, 0, 1, -1, 0);

        for (int i = 0; i < 12; i++) begin
            int h = int'($urandom_range(1400));
            int s = int'($urandom_range(140));
            send_frame(h, s, h > 999 ? 999 : h, s > 99 ? 99 : s, h > 999 || s > 99,
                       int'($urandom_range(60)), 0, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
